cfa_window_5tap: RTL and testbench

//  Streaming 5-tap neighbourhood generator for the CFA green-interpolation path; sits directly upstream of green_h_v.

---
 rtl/cfa_window_5tap.sv | 138 +++++++++++++
 tb/tb_cfa_window_5tap.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cfa_window_5tap.sv
// rtl/cfa_window_5tap.sv - streaming 5x5 cross-shaped tap generator for CFA green interpolation
module cfa_window_5tap #(
    parameter int pixelBitWidth = 12,
    parameter int IMG_WIDTH     = 640,
    parameter int IMG_HEIGHT    = 480,
    parameter int COL_W         = 10,
    parameter int ROW_W         = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [pixelBitWidth-1:0] in_pixel,
    output logic                     out_valid,
    output logic                     out_sof,
    output logic [ROW_W-1:0]         out_row,
    output logic [COL_W-1:0]         out_col,
    output logic [pixelBitWidth-1:0] h_m2,
    output logic [pixelBitWidth-1:0] h_m1,
    output logic [pixelBitWidth-1:0] h_c,
    output logic [pixelBitWidth-1:0] h_p1,
    output logic [pixelBitWidth-1:0] h_p2,
    output logic [pixelBitWidth-1:0] v_m2,
    output logic [pixelBitWidth-1:0] v_m1,
    output logic [pixelBitWidth-1:0] v_c,
    output logic [pixelBitWidth-1:0] v_p1,
    output logic [pixelBitWidth-1:0] v_p2
);

    localparam int PW = pixelBitWidth;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_EMIT = COL_W'(4);
    localparam logic [ROW_W-1:0] ROW_EMIT = ROW_W'(4);

    // Counters hold the position the next accepted pixel will take
    logic [ROW_W-1:0] row_cnt;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] cur_row;
    logic [COL_W-1:0] cur_col;

    // Line buffers: lb0 holds row-1, lb1 row-2, lb2 row-3, lb3 row-4 at each column
    logic [PW-1:0] lb0 [0:IMG_WIDTH-1];
    logic [PW-1:0] lb1 [0:IMG_WIDTH-1];
    logic [PW-1:0] lb2 [0:IMG_WIDTH-1];
    logic [PW-1:0] lb3 [0:IMG_WIDTH-1];
    logic [PW-1:0] lb0_rd, lb1_rd, lb2_rd, lb3_rd;

    // Horizontal history of row-2 samples; index 3 is the oldest (col-4),
    // the fifth stage is the tap register itself
    logic [3:0][PW-1:0] h_sr;

    // Column vectors, index 4 = oldest row (v_m2), index 0 = newest row (v_p2)
    logic [4:0][PW-1:0] v_vec;
    logic [4:0][PW-1:0] v_d1;
    logic [4:0][PW-1:0] v_d2;

    logic emit;

    // Position of the current pixel (sof forces the origin) and emit gate
    always_comb begin
        cur_row = in_sof ? '0 : row_cnt;
        cur_col = in_sof ? '0 : col_cnt;
        lb0_rd  = lb0[cur_col];
        lb1_rd  = lb1[cur_col];
        lb2_rd  = lb2[cur_col];
        lb3_rd  = lb3[cur_col];
        v_vec   = {lb3_rd, lb2_rd, lb1_rd, lb0_rd, in_pixel};
        emit    = in_valid && (cur_row >= ROW_EMIT) && (cur_col >= COL_EMIT);
    end

    // Line-buffer cascade, read-before-write; contents survive reset
    always_ff @(posedge clk) begin
        if (rst && in_valid) begin
            lb0[cur_col] <= in_pixel;
            lb1[cur_col] <= lb0_rd;
            lb2[cur_col] <= lb1_rd;
            lb3[cur_col] <= lb2_rd;
        end
    end

    // Counters, tap history and registered window outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            row_cnt   <= '0;
            col_cnt   <= '0;
            h_sr      <= '0;
            v_d1      <= '0;
            v_d2      <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            h_m2      <= '0;
            h_m1      <= '0;
            h_c       <= '0;
            h_p1      <= '0;
            h_p2      <= '0;
            v_m2      <= '0;
            v_m1      <= '0;
            v_c       <= '0;
            v_p1      <= '0;
            v_p2      <= '0;
        end else begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            if (in_valid) begin
                if (cur_col == COL_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
                end else begin
                    col_cnt <= cur_col + COL_W'(1);
                    row_cnt <= cur_row;
                end
                h_sr <= {h_sr[2:0], lb1_rd};
                v_d1 <= v_vec;
                v_d2 <= v_d1;
            end
            if (emit) begin
                out_valid <= 1'b1;
                out_sof   <= (cur_row == ROW_EMIT) && (cur_col == COL_EMIT);
                out_row   <= cur_row - ROW_W'(2);
                out_col   <= cur_col - COL_W'(2);
                h_m2      <= h_sr[3];
                h_m1      <= h_sr[2];
                h_c       <= h_sr[1];
                h_p1      <= h_sr[0];
                h_p2      <= lb1_rd;
                v_m2      <= v_d2[4];
                v_m1      <= v_d2[3];
                v_c       <= v_d2[2];
                v_p1      <= v_d2[1];
                v_p2      <= v_d2[0];
            end
        end
    end

endmodule

// File: tb/tb_cfa_window_5tap.sv
// tb/tb_cfa_window_5tap.sv - self-checking bench for cfa_window_5tap
module tb_cfa_window_5tap;

    localparam int W = 8;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_sof;
    logic [11:0] in_pixel;
    logic        out_valid, out_sof;
    logic [2:0]  out_row, out_col;
    logic [11:0] h_m2, h_m1, h_c, h_p1, h_p2;
    logic [11:0] v_m2, v_m1, v_c, v_p1, v_p2;

    cfa_window_5tap #(
        .pixelBitWidth(12), .IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_W(3), .ROW_W(3)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_sof(out_sof), .out_row(out_row), .out_col(out_col),
        .h_m2(h_m2), .h_m1(h_m1), .h_c(h_c), .h_p1(h_p1), .h_p2(h_p2),
        .v_m2(v_m2), .v_m1(v_m1), .v_c(v_c), .v_p1(v_p1), .v_p2(v_p2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               r;
        int               c;
        logic [4:0][11:0] h;
        logic [4:0][11:0] v;
    } vec_t;

    typedef struct {
        int               r;
        int               c;
        bit               sof;
        logic [4:0][11:0] h;
        logic [4:0][11:0] v;
    } win_t;

    vec_t tbl [8];
    win_t cap [$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: per-column sample history (index 0 newest) plus position tracking
    int               hist [W][5];
    int               m_row, m_col;
    logic             e_valid, e_sof;
    logic [2:0]       e_row, e_col;
    logic [4:0][11:0] e_h, e_v;

    task automatic chk(input string name, input bit ok, input string act, input string req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s expected %s", name, act, req);
    endtask

    task automatic model_edge(input logic rn, input logic v, input logic s, input logic [11:0] p);
        int r, c;
        if (!rn) begin
            m_row = 0; m_col = 0;
            e_valid = 0; e_sof = 0; e_row = 0; e_col = 0; e_h = '0; e_v = '0;
        end else begin
            e_valid = 0;
            e_sof   = 0;
            if (v) begin
                r = s ? 0 : m_row;
                c = s ? 0 : m_col;
                for (int k = 4; k > 0; k--) hist[c][k] = hist[c][k-1];
                hist[c][0] = int'(p);
                if (r >= 4 && c >= 4) begin
                    e_valid = 1;
                    e_sof   = (r == 4 && c == 4);
                    e_row   = 3'(r - 2);
                    e_col   = 3'(c - 2);
                    for (int k = 0; k < 5; k++) begin
                        e_h[4-k] = 12'(hist[c-4+k][2]);
                        e_v[k]   = 12'(hist[c-2][k]);
                    end
                end
                m_col = c + 1;
                m_row = r;
                if (m_col == W) begin
                    m_col = 0;
                    m_row = (r + 1 == H) ? 0 : r + 1;
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [11:0] p);
        logic [127:0] got, req;
        win_t w;
        in_valid = v;
        in_sof   = s;
        in_pixel = p;
        model_edge(rst, v, s, p);
        @(posedge clk);
        #1;
        got = {out_valid, out_sof, out_row, out_col, h_m2, h_m1, h_c, h_p1, h_p2,
               v_m2, v_m1, v_c, v_p1, v_p2};
        req = {e_valid, e_sof, e_row, e_col, e_h, e_v};
        chk("cycle_outputs", got === req, $sformatf("%h", got), $sformatf("%h", req));
        if (out_valid) begin
            w.r = int'(out_row); w.c = int'(out_col); w.sof = out_sof;
            w.h = {h_m2, h_m1, h_c, h_p1, h_p2};
            w.v = {v_m2, v_m1, v_c, v_p1, v_p2};
            cap.push_back(w);
        end
    endtask

    task automatic send_frame(input int off, input bit sof_first, input bit toggle);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                step(1'b1, sof_first && r == 0 && c == 0, 12'(off + r*16 + c));
                if (toggle) step(1'b0, 1'b0, 12'($urandom));
            end
    endtask

    // Compare n captured windows against the table (repeating every 8), taps offset by off
    task automatic check_windows(input string name, input int n, input int off);
        chk({name, "_count"}, cap.size() == n, $sformatf("%0d", cap.size()), $sformatf("%0d", n));
        for (int i = 0; i < n && i < cap.size(); i++) begin
            vec_t e;
            logic [4:0][11:0] eh, ev;
            bit ok;
            e = tbl[i % 8];
            for (int k = 0; k < 5; k++) begin
                eh[k] = e.h[k] + 12'(off);
                ev[k] = e.v[k] + 12'(off);
            end
            ok = cap[i].r == e.r && cap[i].c == e.c && cap[i].sof == (i % 8 == 0) &&
                 cap[i].h == eh && cap[i].v == ev;
            chk({name, "_window"}, ok,
                $sformatf("r%0d c%0d sof%0d h%h v%h", cap[i].r, cap[i].c, cap[i].sof, cap[i].h, cap[i].v),
                $sformatf("r%0d c%0d sof%0d h%h v%h", e.r, e.c, i % 8 == 0, eh, ev));
        end
    endtask

    initial begin
        tbl[0] = '{2, 2, {12'h020, 12'h021, 12'h022, 12'h023, 12'h024}, {12'h002, 12'h012, 12'h022, 12'h032, 12'h042}};
        tbl[1] = '{2, 3, {12'h021, 12'h022, 12'h023, 12'h024, 12'h025}, {12'h003, 12'h013, 12'h023, 12'h033, 12'h043}};
        tbl[2] = '{2, 4, {12'h022, 12'h023, 12'h024, 12'h025, 12'h026}, {12'h004, 12'h014, 12'h024, 12'h034, 12'h044}};
        tbl[3] = '{2, 5, {12'h023, 12'h024, 12'h025, 12'h026, 12'h027}, {12'h005, 12'h015, 12'h025, 12'h035, 12'h045}};
        tbl[4] = '{3, 2, {12'h030, 12'h031, 12'h032, 12'h033, 12'h034}, {12'h012, 12'h022, 12'h032, 12'h042, 12'h052}};
        tbl[5] = '{3, 3, {12'h031, 12'h032, 12'h033, 12'h034, 12'h035}, {12'h013, 12'h023, 12'h033, 12'h043, 12'h053}};
        tbl[6] = '{3, 4, {12'h032, 12'h033, 12'h034, 12'h035, 12'h036}, {12'h014, 12'h024, 12'h034, 12'h044, 12'h054}};
        tbl[7] = '{3, 5, {12'h033, 12'h034, 12'h035, 12'h036, 12'h037}, {12'h015, 12'h025, 12'h035, 12'h045, 12'h055}};
        for (int c = 0; c < W; c++)
            for (int k = 0; k < 5; k++) hist[c][k] = 0;

        // Reset state
        rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
        step(1'b0, 1'b0, 12'h0);
        step(1'b1, 1'b1, 12'hABC);
        rst = 1'b1;

        // Continuous frame
        cap.delete();
        send_frame(0, 1'b1, 1'b0);
        check_windows("continuous", 8, 0);

        // Same frame with in_valid toggling
        cap.delete();
        send_frame(0, 1'b1, 1'b1);
        check_windows("toggle", 8, 0);

        // Two back-to-back frames, sof only on the first
        cap.delete();
        send_frame(0, 1'b1, 1'b0);
        send_frame(0, 1'b0, 1'b0);
        check_windows("back2back", 16, 0);

        // Mid-frame sof at pixel (3,5)
        cap.delete();
        for (int i = 0; i < 3*W + 5; i++)
            step(1'b1, i == 0, 12'((i / W)*16 + (i % W)));
        send_frame(12'h100, 1'b1, 1'b0);
        check_windows("mid_sof", 8, 12'h100);

        // Reset for one clock mid-frame, then a fresh frame
        for (int i = 0; i < 4*W + 6; i++)
            step(1'b1, i == 0, 12'((i / W)*16 + (i % W)));
        rst = 1'b0;
        step(1'b1, 1'b0, 12'h7FF);
        rst = 1'b1;
        step(1'b0, 1'b0, 12'h0);
        cap.delete();
        send_frame(12'h200, 1'b1, 1'b0);
        check_windows("after_reset", 8, 12'h200);

        // Randomized traffic against the model
        step(1'b1, 1'b1, 12'($urandom));
        for (int i = 0; i < 1500; i++) begin
            logic v;
            v = ($urandom % 4) != 0;
            step(v, v && ($urandom % 200) == 0, 12'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
